// File: rtl/pwm_bank_pkg.sv
// Shared constants for the PWM bank: mode encoding and default sizing.
package pwm_bank_pkg;

    // center_mode input encoding
    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam int unsigned DEFAULT_WIDTH          = 16;
    localparam int unsigned DEFAULT_CHANNELS       = 4;
    localparam int unsigned DEFAULT_PRESCALE_WIDTH = 8;

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: shadowed compare value, level compare and output polarity.
module pwm_bank_channel
    import pwm_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             counter_enable,
    input  logic             reload,
    input  logic             channel_enable,
    input  logic             invert,
    input  logic [WIDTH-1:0] compare,
    input  logic [WIDTH-1:0] counter,
    output logic             pwm_out
);

    logic [WIDTH-1:0] cmp_q;
    logic             pwm_q;
    logic             raw;
    logic             load;

    // Shadow follows the input while the channel or counter is idle so a
    // freshly enabled channel starts with the current compare value.
    assign load = reload | ~counter_enable | ~channel_enable;
    assign raw  = channel_enable & counter_enable & (counter >= cmp_q);

    // Shadow register and registered, polarity-adjusted output
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            if (load) begin
                cmp_q <= compare;
            end
            pwm_q <= raw ^ invert;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator with a shared prescaled edge/center counter.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned CHANNELS       = DEFAULT_CHANNELS,
    parameter int unsigned PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      counter_enable,
    input  logic                      center_mode,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]          top,
    input  logic [CHANNELS*WIDTH-1:0] compare,
    input  logic [CHANNELS-1:0]       channel_enable,
    input  logic [CHANNELS-1:0]       invert,
    output logic [WIDTH-1:0]          counter_value,
    output logic                      period_start,
    output logic [CHANNELS-1:0]       pwm_out
);

    logic [WIDTH-1:0]          count_q, count_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic                      dir_down_q, dir_down_d;
    logic [WIDTH-1:0]          top_q;
    logic                      enable_q;
    logic                      period_start_q;
    logic                      start;
    logic                      tick;
    logic                      reload;

    // First enabled clock opens a period at 0 instead of advancing the counter.
    assign start = counter_enable & ~enable_q;
    // >= so a prescale lowered below the running prescaler ticks at once.
    assign tick  = counter_enable & enable_q & (presc_q >= prescale);

    // Next-state prescaler, counter and direction
    always_comb begin
        count_d    = count_q;
        presc_d    = presc_q;
        dir_down_d = dir_down_q;
        if (!counter_enable || start) begin
            count_d    = '0;
            presc_d    = '0;
            dir_down_d = 1'b0;
        end else begin
            presc_d = tick ? '0 : presc_q + PRESCALE_WIDTH'(1);
            case (center_mode)
                MODE_EDGE: begin
                    dir_down_d = 1'b0;
                    if (tick) begin
                        count_d = (count_q >= top_q) ? '0 : count_q + WIDTH'(1);
                    end
                end
                MODE_CENTER: begin
                    if (tick) begin
                        if (top_q == '0) begin
                            count_d    = '0;
                            dir_down_d = 1'b0;
                        end else if (!dir_down_q && (count_q >= top_q)) begin
                            count_d    = top_q - WIDTH'(1);
                            dir_down_d = 1'b1;
                        end else if (!dir_down_q) begin
                            count_d = count_q + WIDTH'(1);
                        end else if (count_q == '0) begin
                            count_d    = WIDTH'(1);
                            dir_down_d = 1'b0;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Period boundary: the tick that lands the counter on 0, or a fresh start.
    assign reload = start | (tick & (count_d == '0));

    // Counter, prescaler, direction, top shadow and period pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q        <= '0;
            presc_q        <= '0;
            dir_down_q     <= 1'b0;
            top_q          <= '0;
            enable_q       <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            presc_q        <= presc_d;
            dir_down_q     <= dir_down_d;
            enable_q       <= counter_enable;
            period_start_q <= reload;
            if (reload || !counter_enable) begin
                top_q <= top;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        pwm_bank_channel #(
            .WIDTH(WIDTH)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .counter_enable(counter_enable),
            .reload        (reload),
            .channel_enable(channel_enable[i]),
            .invert        (invert[i]),
            .compare       (compare[i*WIDTH +: WIDTH]),
            .counter       (count_q),
            .pwm_out       (pwm_out[i])
        );
    end

    assign counter_value = count_q;
    assign period_start  = period_start_q;

endmodule
